// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg : opcode constants, FSM state encoding and decode helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ----------------------------------------------------------------------------
// load_align : big-endian byte/half select with sign or zero extension
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module load_align
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[31:24];
    case (addr)
      2'b00:   w_byte = rdata[31:24];
      2'b01:   w_byte = rdata[23:16];
      2'b10:   w_byte = rdata[15:8];
      default: w_byte = rdata[7:0];
    endcase
    // Misaligned halfword accesses fall back to the half chosen by addr[1].
    w_half = addr[1] ? rdata[15:0] : rdata[31:16];

    value = rdata;
    case (opcode)
      OP_LB:   value = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  value = {24'h0, w_byte};
      OP_LH:   value = {{16{w_half[15]}}, w_half};
      OP_LHU:  value = {16'h0, w_half};
      default: value = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_writeback.sv
// ----------------------------------------------------------------------------
// mem_writeback : MEM/WB stage, load handshake and single registered RF write
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_writeback
  import mips_pkg::*;
#(
  parameter int         TIMEOUT = 16,
  parameter logic [4:0] R31     = 5'd31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic        rt_rd,
  input  logic        reg_write,
  input  logic [31:0] alu_result,
  input  logic [15:0] immediate,
  input  logic [31:0] pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        load_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  wb_state_e   state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]  op_q, op_d;
  logic [4:0]  dst_q, dst_d;
  logic [1:0]  lane_q, lane_d;
  logic        rw_q, rw_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        err_q, err_d;
  logic [4:0]  dest;
  logic [31:0] load_val;

  load_align u_align (
    .opcode (op_q),
    .addr   (lane_q),
    .rdata  (mem_rdata),
    .value  (load_val)
  );

  assign dest = rt_rd ? rt : rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      addr_q    <= 32'h0;
      cnt_q     <= '0;
      op_q      <= 6'h0;
      dst_q     <= 5'h0;
      lane_q    <= 2'h0;
      rw_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'h0;
      wr_data_q <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      lane_q    <= lane_d;
      rw_q      <= rw_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  // The write registers are loaded on the edge entering WRITE, so wr_en is
  // high exactly while the FSM sits in WRITE.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    dst_d     = dst_q;
    lane_d    = lane_q;
    rw_d      = rw_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_load(opcode)) begin
            op_d    = opcode;
            dst_d   = dest;
            lane_d  = alu_result[1:0];
            rw_d    = reg_write;
            req_d   = 1'b1;
            addr_d  = {alu_result[31:2], 2'b00};
            cnt_d   = '0;
            state_d = ST_MEM_WAIT;
          end else begin
            state_d = ST_WRITE;
            if (opcode == OP_JAL) begin
              wr_addr_d = R31;
              wr_data_d = pc + 32'd4;
              wr_en_d   = (R31 != 5'd0);
            end else if (opcode == OP_LUI) begin
              wr_addr_d = rt;
              wr_data_d = {immediate, 16'h0};
              wr_en_d   = reg_write && (rt != 5'd0);
            end else begin
              wr_addr_d = dest;
              wr_data_d = alu_result;
              wr_en_d   = reg_write && (dest != 5'd0);
            end
          end
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          req_d     = 1'b0;
          wr_addr_d = dst_q;
          wr_data_d = load_val;
          wr_en_d   = rw_q && (dst_q != 5'd0);
          state_d   = ST_WRITE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign in_ready = (state_q == ST_IDLE);
  assign mem_req  = req_q;
  assign mem_addr = addr_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign load_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_writeback.sv
// ----------------------------------------------------------------------------
// tb_mem_writeback : directed self-checking bench for mem_writeback
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = 6'h0;
  logic [4:0]  rt = 5'h0;
  logic [4:0]  rd = 5'h0;
  logic        rt_rd = 1'b0;
  logic        reg_write = 1'b0;
  logic [31:0] alu_result = 32'h0;
  logic [15:0] immediate = 16'h0;
  logic [31:0] pc = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        load_err;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_writeback #(.TIMEOUT(16), .R31(5'd31)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .rt         (rt),
    .rd         (rd),
    .rt_rd      (rt_rd),
    .reg_write  (reg_write),
    .alu_result (alu_result),
    .immediate  (immediate),
    .pc         (pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] t, input logic [4:0] d,
                       input logic sel, input logic rw, input logic [31:0] alu,
                       input logic [15:0] imm, input logic [31:0] p);
    opcode = op; rt = t; rd = d; rt_rd = sel; reg_write = rw;
    alu_result = alu; immediate = imm; pc = p; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({mem_req, wr_en, load_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got req/wr_en/err=%b want 000", {mem_req, wr_en, load_err});
    end
    n_cmp++;
    if ({mem_addr, wr_addr, wr_data} !== 69'h0) begin
      n_fail++; $display("FAIL reset_data: got addr=%h wr_addr=%0d wr_data=%h want 0", mem_addr, wr_addr, wr_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_lw();
    int bad_ready = 0;
    issue(6'b100011, 5'd8, 5'd0, 1'b1, 1'b1, 32'h100, 16'h0, 32'h0);
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL lw_req: got req=%b addr=%h want 1/00000100", mem_req, mem_addr);
    end
    if (in_ready !== 1'b0) bad_ready++;
    // A stray instruction while waiting must be ignored.
    opcode = 6'b000000; rd = 5'd9; rt_rd = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (in_ready !== 1'b0 || wr_en !== 1'b0) bad_ready++;
    tick();
    if (in_ready !== 1'b0 || wr_en !== 1'b0 || mem_req !== 1'b1) bad_ready++;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    if (in_ready !== 1'b0) bad_ready++;
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd8 || wr_data !== 32'hDEADBEEF || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL lw_write: got en=%b addr=%0d data=%h req=%b want 1/8/deadbeef/0", wr_en, wr_addr, wr_data, mem_req);
    end
    tick();
    n_cmp++;
    if (wr_en !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL lw_done: got en=%b ready=%b want 0/1", wr_en, in_ready);
    end
    n_cmp++;
    if (bad_ready != 0) begin
      n_fail++; $display("FAIL lw_wait: got %0d bad wait cycles want 0", bad_ready);
    end
  endtask

  task automatic test_extract();
    logic [5:0]  ops [4] = '{6'b100000, 6'b100100, 6'b100001, 6'b100101};
    logic [31:0] adr [4] = '{32'h103, 32'h101, 32'h102, 32'h100};
    logic [31:0] exp [4] = '{32'hFFFFFFF0, 32'h00000034, 32'h000056F0, 32'h00001234};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 5'd12, 5'd0, 1'b1, 1'b1, adr[i], 16'h0, 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h123456F0;
      tick();
      mem_ack = 1'b0;
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd12 || wr_data !== exp[i]) begin
        n_fail++; $display("FAIL extract_%0d: got en=%b addr=%0d data=%h want 1/12/%h", i, wr_en, wr_addr, wr_data, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_jal_lui();
    mem_ack = 1'b1;  // ack outside MEM_WAIT is ignored
    issue(6'b000011, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 16'h0, 32'h0040001C);
    mem_ack = 1'b0;
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd31 || wr_data !== 32'h00400020 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL jal: got en=%b addr=%0d data=%h req=%b want 1/31/00400020/0", wr_en, wr_addr, wr_data, mem_req);
    end
    tick();
    issue(6'b001111, 5'd3, 5'd7, 1'b0, 1'b1, 32'h0, 16'hABCD, 32'h0);
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'hABCD0000) begin
      n_fail++; $display("FAIL lui: got en=%b addr=%0d data=%h want 1/3/abcd0000", wr_en, wr_addr, wr_data);
    end
    tick();
  endtask

  task automatic test_reg0();
    int pulses = 0;
    issue(6'b000000, 5'd4, 5'd0, 1'b0, 1'b1, 32'h55, 16'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (wr_en === 1'b1) pulses++;
      tick();
    end
    n_cmp++;
    if (pulses != 0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reg0: got pulses=%0d ready=%b want 0/1", pulses, in_ready);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int pulses = 0;
    issue(6'b100011, 5'd6, 5'd0, 1'b1, 1'b1, 32'h200, 16'h0, 32'h0);
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      if (wr_en === 1'b1) pulses++;
      tick();
    end
    n_cmp++;
    if (n != 16) begin
      n_fail++; $display("FAIL timeout_len: got %0d req cycles want 16", n);
    end
    n_cmp++;
    if (load_err !== 1'b1 || pulses != 0 || wr_en !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL timeout_state: got err=%b pulses=%0d en=%b ready=%b want 1/0/0/1", load_err, pulses, wr_en, in_ready);
    end
    issue(6'b000000, 5'd2, 5'd5, 1'b0, 1'b1, 32'h77, 16'h0, 32'h0);
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'h77 || load_err !== 1'b1) begin
      n_fail++; $display("FAIL after_timeout: got en=%b addr=%0d data=%h err=%b want 1/5/00000077/1", wr_en, wr_addr, wr_data, load_err);
    end
    tick();
  endtask

  task automatic test_reset_midload();
    issue(6'b100011, 5'd10, 5'd0, 1'b1, 1'b1, 32'h300, 16'h0, 32'h0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || load_err !== 1'b0 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rst_midload: got req=%b err=%b addr=%h want 0/0/0", mem_req, load_err, mem_addr);
    end
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0;
    tick();
    n_cmp++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'h0 || mem_req !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL late_ack: got en=%b addr=%0d data=%h req=%b ready=%b want 0/0/0/0/1", wr_en, wr_addr, wr_data, mem_req, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_extract();
    test_jal_lui();
    test_reg0();
    test_timeout();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
